// File: rtl/mips_register_file.sv
// 32 x DATA_W MIPS general-purpose register file: two combinational read ports,
// one synchronous write port with same-cycle write-to-read bypass; $zero is hardwired.
module mips_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_en;

  assign wr_en = regwrite && (rd != '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[rd] = writedata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reset dominates the bypass so both ports read zero while rst is low.
  always_comb begin
    A = regs_q[rs];
    if (!rst || rs == '0) begin
      A = '0;
    end else if (wr_en && rd == rs) begin
      A = writedata;
    end
  end

  always_comb begin
    B = regs_q[rt];
    if (!rst || rt == '0) begin
      B = '0;
    end else if (wr_en && rd == rt) begin
      B = writedata;
    end
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_mips_register_file;

  logic        clk;
  logic        rst;
  logic        regwrite;
  logic [4:0]  rs, rt, rd;
  logic [31:0] writedata;
  logic [31:0] A, B;

  logic [31:0] model [32];
  int n_checks = 0;
  int n_pass   = 0;

  mips_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .regwrite(regwrite),
    .rs(rs), .rt(rt), .rd(rd), .writedata(writedata),
    .A(A), .B(B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read port should show right now, from the architectural rules.
  function automatic logic [31:0] expect_read(input logic [4:0] addr);
    if (!rst || addr == 5'd0) return 32'h0;
    if (regwrite && rd == addr) return writedata;
    return model[addr];
  endfunction

  // Advance one rising edge, committing any write to the model, then settle.
  task automatic cycle();
    if (rst && regwrite && rd != 5'd0) model[rd] = writedata;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] ea, eb;
    rs = 5'd4; rt = 5'd9;
    #2;
    ea = 32'h0; eb = 32'h0;
    n_checks++; if (A !== ea) $display("FAIL reset_A got=%h want=%h", A, ea); else n_pass++;
    n_checks++; if (B !== eb) $display("FAIL reset_B got=%h want=%h", B, eb); else n_pass++;
    #8 rst = 1'b1;
    @(posedge clk); #1;
    $display("reset: A=%h B=%h", A, B);
  endtask

  task automatic test_write_read();
    regwrite = 1'b1; rd = 5'd2; writedata = 32'h12345678;
    cycle();
    regwrite = 1'b0; rs = 5'd2; rt = 5'd1;
    #1;
    $display("write r2: A=%h B=%h", A, B);
    n_checks++; if (A !== 32'h12345678) $display("FAIL wr_r2_A got=%h want=%h", A, 32'h12345678); else n_pass++;
    n_checks++; if (B !== 32'h0) $display("FAIL wr_r1_B got=%h want=%h", B, 32'h0); else n_pass++;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    clear_model();
    $display("async reset asserted: A=%h", A);
    n_checks++; if (A !== 32'h0) $display("FAIL arst_during_A got=%h want=%h", A, 32'h0); else n_pass++;
    // Try a write while in reset; it must be blocked.
    regwrite = 1'b1; rd = 5'd2; writedata = 32'hA5A5A5A5;
    #1;
    n_checks++; if (A !== 32'h0) $display("FAIL arst_bypass_A got=%h want=%h", A, 32'h0); else n_pass++;
    #7 rst = 1'b1;
    regwrite = 1'b0;
    #1;
    $display("async reset released: A=%h", A);
    n_checks++; if (A !== 32'h0) $display("FAIL arst_after_A got=%h want=%h", A, 32'h0); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_second_write();
    regwrite = 1'b1; rd = 5'd3; writedata = 32'h87654321;
    cycle();
    regwrite = 1'b0; rs = 5'd3; rt = 5'd0;
    #1;
    $display("write r3: A=%h B=%h", A, B);
    n_checks++; if (A !== 32'h87654321) $display("FAIL wr_r3_A got=%h want=%h", A, 32'h87654321); else n_pass++;
    n_checks++; if (B !== 32'h0) $display("FAIL r0_B got=%h want=%h", B, 32'h0); else n_pass++;
  endtask

  task automatic test_zero_protect();
    regwrite = 1'b1; rd = 5'd0; writedata = 32'hFFFFFFFF; rs = 5'd0; rt = 5'd0;
    #1;
    n_checks++; if (A !== 32'h0) $display("FAIL zero_bypass_A got=%h want=%h", A, 32'h0); else n_pass++;
    cycle();
    regwrite = 1'b0;
    #1;
    $display("zero write: A=%h B=%h", A, B);
    n_checks++; if (A !== 32'h0) $display("FAIL zero_A got=%h want=%h", A, 32'h0); else n_pass++;
    n_checks++; if (B !== 32'h0) $display("FAIL zero_B got=%h want=%h", B, 32'h0); else n_pass++;
  endtask

  task automatic test_bypass();
    regwrite = 1'b1; rd = 5'd5; writedata = 32'hDEADBEEF; rs = 5'd5; rt = 5'd5;
    #1;
    $display("bypass r5: A=%h B=%h", A, B);
    n_checks++; if (A !== 32'hDEADBEEF) $display("FAIL bypass_A got=%h want=%h", A, 32'hDEADBEEF); else n_pass++;
    n_checks++; if (B !== 32'hDEADBEEF) $display("FAIL bypass_B got=%h want=%h", B, 32'hDEADBEEF); else n_pass++;
    cycle();
    regwrite = 1'b0; writedata = 32'h0;
    #1;
    n_checks++; if (A !== 32'hDEADBEEF) $display("FAIL post_bypass_A got=%h want=%h", A, 32'hDEADBEEF); else n_pass++;
    n_checks++; if (B !== 32'hDEADBEEF) $display("FAIL post_bypass_B got=%h want=%h", B, 32'hDEADBEEF); else n_pass++;
  endtask

  task automatic test_write_disabled();
    regwrite = 1'b0; rd = 5'd7; writedata = 32'h1; rs = 5'd7; rt = 5'd7;
    for (int i = 0; i < 3; i++) cycle();
    $display("write disabled r7: A=%h B=%h", A, B);
    n_checks++; if (A !== 32'h0) $display("FAIL wdis_A got=%h want=%h", A, 32'h0); else n_pass++;
    n_checks++; if (B !== 32'h0) $display("FAIL wdis_B got=%h want=%h", B, 32'h0); else n_pass++;
  endtask

  task automatic test_sweep();
    logic [31:0] want;
    regwrite = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i);
      writedata = 32'hC0DE0000 | (32'(i) * 32'h01010101);
      cycle();
    end
    regwrite = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs = 5'(i); rt = 5'(32 - i);
      #1;
      want = 32'hC0DE0000 | (32'(i) * 32'h01010101);
      n_checks++; if (A !== want) $display("FAIL sweep_A r%0d got=%h want=%h", i, A, want); else n_pass++;
      want = 32'hC0DE0000 | (32'(32 - i) * 32'h01010101);
      n_checks++; if (B !== want) $display("FAIL sweep_B r%0d got=%h want=%h", 32 - i, B, want); else n_pass++;
    end
    $display("sweep: 31 registers read back on both ports");
  endtask

  task automatic test_random();
    logic [31:0] ea, eb;
    for (int n = 0; n < 300; n++) begin
      regwrite  = 1'($urandom_range(0, 1));
      rd        = 5'($urandom_range(0, 31));
      writedata = $urandom;
      rs        = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt        = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      ea = expect_read(rs);
      eb = expect_read(rt);
      n_checks++; if (A !== ea) $display("FAIL rand_A n=%0d rs=%0d got=%h want=%h", n, rs, A, ea); else n_pass++;
      n_checks++; if (B !== eb) $display("FAIL rand_B n=%0d rt=%0d got=%h want=%h", n, rt, B, eb); else n_pass++;
      cycle();
    end
    $display("random: 300 transactions");
  endtask

  initial begin
    rst = 1'b0; regwrite = 1'b0; rs = '0; rt = '0; rd = '0; writedata = '0;
    clear_model();
    test_reset();
    test_write_read();
    test_async_reset();
    test_second_write();
    test_zero_protect();
    test_bypass();
    test_write_disabled();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
